// File: rtl/call_stack.sv
// Return-address LIFO for the single-cycle CPU: JAL pushes the return PC, RET pops it.
// Show-ahead top of stack, full/empty/count status, sticky overflow/underflow flags.
module call_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic                       err_clr,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] SpOne  = CW'(1);
  localparam logic [CW-1:0] SpFull = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    sp_q, sp_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    free_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == SpFull);
  // Truncation is safe: these indices are only used while the slot is valid.
  assign top_idx  = AW'(sp_q - SpOne);
  assign free_idx = AW'(sp_q);

  always_comb begin
    sp_d        = sp_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = free_idx;

    // Clear first so that a new error in the same cycle wins.
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    if (flush) begin
      sp_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!is_full) begin
            we   = 1'b1;
            sp_d = sp_q + SpOne;
          end else begin
            overflow_d = 1'b1;
          end
        end
        2'b01: begin
          if (!is_empty) begin
            sp_d = sp_q - SpOne;
          end else begin
            underflow_d = 1'b1;
          end
        end
        2'b11: begin
          if (!is_empty) begin
            we    = 1'b1;
            waddr = top_idx;
          end else begin
            // Nothing to replace: behaves as a plain push, but the pop is still an error.
            we          = 1'b1;
            sp_d        = sp_q + SpOne;
            underflow_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= din;
    end
  end

  assign dout      = is_empty ? '0 : mem[top_idx];
  assign count     = sp_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: table of per-edge vectors plus hand-written
// sequences for show-ahead pop and asynchronous reset mid-cycle.
module tb_call_stack;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic       flush;
  logic       err_clr;
  logic [9:0] din;
  logic [9:0] dout;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  call_stack #(
    .WIDTH(10),
    .DEPTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .err_clr  (err_clr),
    .din      (din),
    .dout     (dout),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       flush;
    logic       clr;
    logic [9:0] din;
    logic [3:0] count;
    logic [9:0] dout;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pu, input logic po, input logic fl, input logic cl,
                     input logic [9:0] d, input logic [3:0] c, input logic [9:0] q,
                     input logic ov, input logic un);
    vec_t v;
    v.push  = pu;
    v.pop   = po;
    v.flush = fl;
    v.clr   = cl;
    v.din   = d;
    v.count = c;
    v.dout  = q;
    v.empty = (c == 4'd0);
    v.full  = (c == 4'd8);
    v.ovf   = ov;
    v.unf   = un;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [9:0] q,
                         input logic e, input logic f, input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".dout"}, 32'(dout), 32'(q));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(un));
  endtask

  task automatic drive(input logic pu, input logic po, input logic fl, input logic cl,
                       input logic [9:0] d);
    push    = pu;
    pop     = po;
    flush   = fl;
    err_clr = cl;
    din     = d;
  endtask

  task automatic step(input logic pu, input logic po, input logic fl, input logic cl,
                      input logic [9:0] d);
    drive(pu, po, fl, cl, d);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);

    //   push pop flush clr din      count dout    ovf unf
    add(1, 0, 0, 0, 10'h101, 4'd1, 10'h101, 0, 0);
    add(1, 0, 0, 0, 10'h202, 4'd2, 10'h202, 0, 0);
    add(1, 0, 0, 0, 10'h303, 4'd3, 10'h303, 0, 0);
    add(0, 1, 0, 0, 10'h000, 4'd2, 10'h202, 0, 0);
    add(1, 1, 0, 0, 10'h055, 4'd2, 10'h055, 0, 0);
    add(0, 1, 0, 0, 10'h000, 4'd1, 10'h101, 0, 0);
    add(0, 1, 0, 0, 10'h000, 4'd0, 10'h000, 0, 0);
    add(0, 1, 0, 0, 10'h000, 4'd0, 10'h000, 0, 1);
    add(0, 0, 0, 1, 10'h000, 4'd0, 10'h000, 0, 0);
    add(1, 1, 0, 0, 10'h077, 4'd1, 10'h077, 0, 1);
    add(1, 0, 0, 1, 10'h011, 4'd2, 10'h011, 0, 0);
    add(1, 0, 0, 0, 10'h012, 4'd3, 10'h012, 0, 0);
    add(1, 0, 0, 0, 10'h013, 4'd4, 10'h013, 0, 0);
    add(1, 0, 0, 0, 10'h014, 4'd5, 10'h014, 0, 0);
    add(1, 0, 0, 0, 10'h015, 4'd6, 10'h015, 0, 0);
    add(1, 0, 0, 0, 10'h016, 4'd7, 10'h016, 0, 0);
    add(1, 0, 0, 0, 10'h017, 4'd8, 10'h017, 0, 0);
    add(1, 0, 0, 0, 10'h3FF, 4'd8, 10'h017, 1, 0);
    add(1, 1, 0, 0, 10'h0AA, 4'd8, 10'h0AA, 1, 0);
    add(0, 1, 0, 0, 10'h000, 4'd7, 10'h016, 1, 0);
    add(0, 1, 0, 0, 10'h000, 4'd6, 10'h015, 1, 0);
    add(0, 1, 0, 0, 10'h000, 4'd5, 10'h014, 1, 0);
    add(1, 0, 1, 0, 10'h1FF, 4'd0, 10'h000, 1, 0);
    add(1, 0, 0, 0, 10'h0C0, 4'd1, 10'h0C0, 1, 0);
    add(0, 0, 1, 1, 10'h000, 4'd0, 10'h000, 0, 0);
    add(1, 0, 0, 0, 10'h123, 4'd1, 10'h123, 0, 0);
    add(0, 0, 0, 0, 10'h000, 4'd1, 10'h123, 0, 0);
    add(0, 1, 0, 0, 10'h000, 4'd0, 10'h000, 0, 0);
    add(0, 1, 0, 1, 10'h000, 4'd0, 10'h000, 0, 1);
    add(0, 0, 0, 1, 10'h000, 4'd0, 10'h000, 0, 0);

    #12;
    chk_all("reset", 4'd0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].dout, vecs[i].empty,
              vecs[i].full, vecs[i].ovf, vecs[i].unf);
    end

    // Show-ahead: during a pop cycle dout still shows the entry being popped.
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h2C1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h2C2);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    #2;
    chk("showahead.dout_before_edge", 32'(dout), 32'h2C2);
    chk("showahead.count_before_edge", 32'(count), 32'd2);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    chk("showahead.dout_after_edge", 32'(dout), 32'h2C1);

    // Async reset mid-cycle during a push at count=3, with underflow set beforehand.
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
    chk("pre_reset.underflow", 32'(underflow), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h301);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h302);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h303);
    chk("pre_reset.count", 32'(count), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 10'h304);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 4'd0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held.count", 32'(count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 10'h2AA);
    chk_all("post_reset_push", 4'd1, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
